pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Drives the IF/ID register's datahazard
//  (hold) and flush inputs, PC hold, ID/EX bubble, and the EX/MEM freeze.

---
 rtl/pipeline_hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch/jump flushes, data-memory waits.
// Define HAZARD_PERF_EN to build the stall/flush performance counters; otherwise they read 0.
module pipeline_hazard_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int WAIT_MAX = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_jump,
  input  logic [4:0]  ex_rt,
  input  logic        ex_memread,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_hold,
  output logic        ifid_datahazard,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        idex_hold,
  output logic        exmem_hold,
  output logic        mem_timeout,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  localparam logic [1:0] LOAD_CNT_INIT = 2'(LOAD_LAT - 1);
  localparam logic [7:0] WAIT_LIMIT    = 8'(WAIT_MAX);

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       timeout_q;
  logic       wait_hit;
  logic       eval_run;
  logic       load_use;
  logic       mem_stall;
  logic       pc_hold_c, ifid_dh_c, ifid_flush_c, idex_flush_c, idex_hold_c, exmem_hold_c;

  assign load_use  = ex_memread & (ex_rt != 5'd0) &
                     ((id_uses_rs & (id_rs == ex_rt)) | (id_uses_rt & (id_rt == ex_rt)));
  assign mem_stall = mem_req & ~mem_ready;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    wait_cnt_nxt = wait_cnt;
    wait_hit     = 1'b0;
    eval_run     = 1'b0;
    pc_hold_c    = 1'b0;
    ifid_dh_c    = 1'b0;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    idex_hold_c  = 1'b0;
    exmem_hold_c = 1'b0;

    case (state)
      LOAD_STALL: begin
        if (mem_stall) begin
          pc_hold_c    = 1'b1;
          ifid_dh_c    = 1'b1;
          idex_hold_c  = 1'b1;
          exmem_hold_c = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd0;
          cnt_nxt      = 2'd0;
        end else if (ex_branch_taken) begin
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
          state_nxt    = RUN;
          cnt_nxt      = 2'd0;
        end else begin
          pc_hold_c    = 1'b1;
          ifid_dh_c    = 1'b1;
          idex_flush_c = 1'b1;
          cnt_nxt      = cnt - 2'd1;
          if (cnt == 2'd1) state_nxt = RUN;
        end
      end
      MEM_WAIT: begin
        // EX is frozen here, so branch/jump inputs are stale and must not act
        if (!mem_ready) begin
          pc_hold_c    = 1'b1;
          ifid_dh_c    = 1'b1;
          idex_hold_c  = 1'b1;
          exmem_hold_c = 1'b1;
          if (wait_cnt != WAIT_LIMIT) wait_cnt_nxt = wait_cnt + 8'd1;
          wait_hit = (wait_cnt_nxt == WAIT_LIMIT);
        end else begin
          eval_run = 1'b1;
        end
      end
      default: eval_run = 1'b1;
    endcase

    if (eval_run) begin
      state_nxt = RUN;
      if (mem_stall) begin
        pc_hold_c    = 1'b1;
        ifid_dh_c    = 1'b1;
        idex_hold_c  = 1'b1;
        exmem_hold_c = 1'b1;
        state_nxt    = MEM_WAIT;
        wait_cnt_nxt = 8'd0;
      end else if (ex_branch_taken) begin
        ifid_flush_c = 1'b1;
        idex_flush_c = 1'b1;
      end else if (load_use) begin
        pc_hold_c    = 1'b1;
        ifid_dh_c    = 1'b1;
        idex_flush_c = 1'b1;
        if (LOAD_LAT > 1) begin
          state_nxt = LOAD_STALL;
          cnt_nxt   = LOAD_CNT_INIT;
        end
      end else if (id_jump) begin
        ifid_flush_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      cnt       <= 2'd0;
      wait_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (wait_hit) timeout_q <= 1'b1;
    end
  end

  // Every output is forced low while reset is asserted
  assign pc_hold         = pc_hold_c    & ~reset;
  assign ifid_datahazard = ifid_dh_c    & ~reset;
  assign ifid_flush      = ifid_flush_c & ~reset;
  assign idex_flush      = idex_flush_c & ~reset;
  assign idex_hold       = idex_hold_c  & ~reset;
  assign exmem_hold      = exmem_hold_c & ~reset;
  assign mem_timeout     = (timeout_q | wait_hit) & ~reset;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if (pc_hold)    stall_q <= stall_q + 32'd1;
      if (ifid_flush) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;
`else
  assign stall_count = 32'd0;
  assign flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: two instances (LOAD_LAT=1/WAIT_MAX=64 and LOAD_LAT=3/WAIT_MAX=4)
// share one stimulus stream; a negedge monitor pops hand-computed expectations and compares.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  // Output vector: {pc_hold, ifid_datahazard, ifid_flush, idex_flush, idex_hold, exmem_hold, mem_timeout}
  localparam logic [6:0] N  = 7'b0000000;
  localparam logic [6:0] S  = 7'b1101000;
  localparam logic [6:0] BR = 7'b0011000;
  localparam logic [6:0] J  = 7'b0010000;
  localparam logic [6:0] F  = 7'b1100110;
  localparam logic [6:0] T  = 7'b0000001;
`ifdef HAZARD_PERF_EN
  localparam logic [31:0] PERF = 32'd1;
`else
  localparam logic [31:0] PERF = 32'd0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic       id_uses_rs = 0, id_uses_rt = 0, id_jump = 0, ex_memread = 0;
  logic       ex_branch_taken = 0, mem_req = 0, mem_ready = 0;

  logic       n_reset;
  logic [4:0] n_rs, n_rt, n_exrt;
  logic       n_urs, n_urt, n_jump, n_mrd, n_br, n_mreq, n_mrdy;

  logic        pch_a, dh_a, iff_a, ief_a, ieh_a, emh_a, to_a;
  logic        pch_b, dh_b, iff_b, ief_b, ieh_b, emh_b, to_b;
  logic [31:0] sc_a, fc_a, sc_b, fc_b;

  pipeline_hazard_ctrl #(.LOAD_LAT(1), .WAIT_MAX(64)) dut_a (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_jump(id_jump), .ex_rt(ex_rt), .ex_memread(ex_memread),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_hold(pch_a), .ifid_datahazard(dh_a), .ifid_flush(iff_a), .idex_flush(ief_a),
    .idex_hold(ieh_a), .exmem_hold(emh_a), .mem_timeout(to_a),
    .stall_count(sc_a), .flush_count(fc_a));

  pipeline_hazard_ctrl #(.LOAD_LAT(3), .WAIT_MAX(4)) dut_b (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_jump(id_jump), .ex_rt(ex_rt), .ex_memread(ex_memread),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_hold(pch_b), .ifid_datahazard(dh_b), .ifid_flush(iff_b), .idex_flush(ief_b),
    .idex_hold(ieh_b), .exmem_hold(emh_b), .mem_timeout(to_b),
    .stall_count(sc_b), .flush_count(fc_b));

  wire [6:0] outs_a = {pch_a, dh_a, iff_a, ief_a, ieh_a, emh_a, to_a};
  wire [6:0] outs_b = {pch_b, dh_b, iff_b, ief_b, ieh_b, emh_b, to_b};

  typedef struct {
    int          id;
    logic [6:0]  ea;
    logic [6:0]  eb;
    logic        chk_cnt;
    logic [31:0] sa, fa, sb, fb;
  } exp_t;

  exp_t sb[$];
  exp_t r;
  int   checks = 0;
  int   errors = 0;
  int   vec    = 0;

  // Monitor: one expectation per stimulus cycle, sampled at the falling edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      r = sb.pop_front();
      checks++;
      if (outs_a !== r.ea) begin
        errors++;
        $display("FAIL vec%0d dut_a outputs got %b expected %b", r.id, outs_a, r.ea);
      end
      checks++;
      if (outs_b !== r.eb) begin
        errors++;
        $display("FAIL vec%0d dut_b outputs got %b expected %b", r.id, outs_b, r.eb);
      end
      if (r.chk_cnt) begin
        checks++;
        if (sc_a !== r.sa || fc_a !== r.fa) begin
          errors++;
          $display("FAIL vec%0d dut_a counters got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                   r.id, sc_a, fc_a, r.sa, r.fa);
        end
        checks++;
        if (sc_b !== r.sb || fc_b !== r.fb) begin
          errors++;
          $display("FAIL vec%0d dut_b counters got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                   r.id, sc_b, fc_b, r.sb, r.fb);
        end
      end
    end
  end

  task automatic idle();
    n_reset = 0; n_rs = 0; n_rt = 0; n_exrt = 0;
    n_urs = 0; n_urt = 0; n_jump = 0; n_mrd = 0; n_br = 0; n_mreq = 0; n_mrdy = 0;
  endtask

  task automatic set_lu();
    idle();
    n_mrd = 1; n_exrt = 5'd8; n_rs = 5'd8; n_urs = 1;
  endtask

  task automatic apply();
    @(posedge clk);
    #1;
    reset = n_reset; id_rs = n_rs; id_rt = n_rt; ex_rt = n_exrt;
    id_uses_rs = n_urs; id_uses_rt = n_urt; id_jump = n_jump; ex_memread = n_mrd;
    ex_branch_taken = n_br; mem_req = n_mreq; mem_ready = n_mrdy;
  endtask

  task automatic cyc(input logic [6:0] ea, input logic [6:0] eb);
    apply();
    vec++;
    sb.push_back('{vec, ea, eb, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0});
  endtask

  task automatic cyc_cnt(input logic [6:0] ea, input logic [6:0] eb,
                         input logic [31:0] sa, input logic [31:0] fa,
                         input logic [31:0] sbv, input logic [31:0] fb);
    apply();
    vec++;
    sb.push_back('{vec, ea, eb, 1'b1, sa, fa, sbv, fb});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a live hazard on the inputs: outputs must stay low
    set_lu(); n_reset = 1;
    cyc(N, N); cyc(N, N);
    idle(); cyc(N, N);

    // Load-use: one stall cycle for LOAD_LAT=1, three for LOAD_LAT=3
    set_lu(); cyc(S, S);
    idle(); cyc(N, S); cyc(N, S); cyc(N, N);

    // Branch beats load-use and jump in the same cycle
    set_lu(); n_br = 1; n_jump = 1; cyc(BR, BR);
    idle(); cyc_cnt(N, N, PERF * 32'd1, PERF * 32'd1, PERF * 32'd3, PERF * 32'd1);

    // Non-hazards: ex_rt=0, source not used, not a load
    idle(); n_mrd = 1; n_exrt = 0; n_rs = 0; n_urs = 1; cyc(N, N);
    idle(); n_mrd = 1; n_exrt = 5'd5; n_rs = 5'd5; n_rt = 5'd9; n_urt = 1; cyc(N, N);
    idle(); n_exrt = 5'd8; n_rs = 5'd8; n_urs = 1; cyc(N, N);

    // Hazard through rt
    idle(); n_mrd = 1; n_exrt = 5'd5; n_rt = 5'd5; n_urt = 1; cyc(S, S);
    idle(); cyc(N, S); cyc(N, S); cyc(N, N);

    // Jump alone, then jump losing to load-use
    idle(); n_jump = 1; cyc(J, J);
    idle(); cyc(N, N);
    set_lu(); n_jump = 1; cyc(S, S);
    idle(); cyc(N, S); cyc(N, S); cyc(N, N);

    // Jump while dut_b is in LOAD_STALL is ignored there
    set_lu(); cyc(S, S);
    idle(); n_jump = 1; cyc(J, S);
    idle(); cyc(N, S); cyc(N, N);

    // Branch during LOAD_STALL flushes and returns to RUN
    set_lu(); cyc(S, S);
    idle(); n_br = 1; cyc(BR, BR);
    idle(); cyc(N, N);

    // Mem wait during LOAD_STALL discards the remaining load count
    set_lu(); cyc(S, S);
    idle(); n_mreq = 1; cyc(F, F);
    idle(); n_mreq = 1; n_mrdy = 1; cyc(N, N);
    idle(); cyc(N, N);

    // Reset in the middle of a load stall
    set_lu(); cyc(S, S);
    idle(); n_reset = 1; cyc(N, N);
    idle(); cyc(N, N);

    // Five-cycle memory wait; branch/jump ignored while frozen; dut_b times out on the fifth
    idle(); n_mreq = 1; n_br = 1; cyc(F, F);
    idle(); n_mreq = 1; n_br = 1; n_jump = 1; cyc(F, F);
    idle(); n_mreq = 1; cyc(F, F); cyc(F, F); cyc(F, F | T);
    idle(); n_mreq = 1; n_mrdy = 1; n_br = 1; cyc(BR, BR | T);
    idle(); cyc(N, T);
    n_reset = 1; cyc(N, N);
    idle(); cyc(N, N);

    // Ten-cycle wait: timeout sticky from the fifth frozen cycle onward
    idle(); n_mreq = 1;
    for (int i = 0; i < 4; i++) cyc(F, F);
    for (int i = 0; i < 6; i++) cyc(F, F | T);
    idle(); n_mreq = 1; n_mrdy = 1; cyc(N, T);
    idle(); cyc(N, T);

    // Reset in the middle of a wait clears the timeout
    idle(); n_mreq = 1; cyc(F, F | T);
    n_reset = 1; cyc(N, N);
    idle(); cyc(N, N);

    @(posedge clk);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain scoreboard left=%0d expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
